// File: rtl/adder_result_fifo.sv
// Output-side FIFO for the 8-bit adder: buffers {carry,sum} results and serves them on valid/ready.
// One-cycle push-to-head latency; a full FIFO without a pop drops the push and records it.
module adder_result_fifo #(
   parameter int DEPTH  = 8,
   parameter int ADDR_W = 3,
   parameter int DROP_W = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              Data_ready,
   input  logic [7:0]        Sum_result,
   input  logic              Sum_carry,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [8:0]        out_data,
   output logic [ADDR_W:0]   fifo_count,
   output logic              full,
   output logic              empty,
   output logic              overflow,
   output logic [DROP_W-1:0] drop_count,
   input  logic              clr_overflow
);

   localparam logic [ADDR_W:0]   FULL_CNT = (ADDR_W+1)'(DEPTH);
   localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W+1)'(1);
   localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);
   localparam logic [DROP_W-1:0] DROP_ONE = DROP_W'(1);

   logic [8:0]        mem [DEPTH];
   logic [ADDR_W-1:0] wr_ptr, rd_ptr, rd_next;
   logic [ADDR_W:0]   count_next;
   logic [8:0]        din;
   logic              pop, push_ok, drop;

   assign din       = {Sum_carry, Sum_result};
   assign empty     = (fifo_count == '0);
   assign full      = (fifo_count == FULL_CNT);
   assign out_valid = !empty;
   assign pop       = out_valid & out_ready;
   assign push_ok   = Data_ready & (!full | pop);
   assign drop      = Data_ready & full & !pop;
   assign rd_next   = pop ? rd_ptr + PTR_ONE : rd_ptr;

   always_comb begin
      count_next = fifo_count;
      if (push_ok && !pop)
         count_next = fifo_count + CNT_ONE;
      else if (pop && !push_ok)
         count_next = fifo_count - CNT_ONE;
   end

   always_ff @(posedge clk) begin
      if (push_ok && !reset)
         mem[wr_ptr] <= din;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_count <= '0;
         out_data   <= '0;
      end else begin
         if (push_ok)
            wr_ptr <= wr_ptr + PTR_ONE;
         rd_ptr     <= rd_next;
         fifo_count <= count_next;
         // Reload the head when it changes; bypass when the new head is the entry being written now.
         if (count_next != '0 && (pop || empty))
            out_data <= (push_ok && wr_ptr == rd_next) ? din : mem[rd_next];
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         overflow   <= 1'b0;
         drop_count <= '0;
      end else if (drop) begin
         overflow   <= 1'b1;
         if (clr_overflow)
            drop_count <= DROP_ONE;
         else if (drop_count != '1)
            drop_count <= drop_count + DROP_ONE;
      end else if (clr_overflow) begin
         overflow   <= 1'b0;
         drop_count <= '0;
      end
   end

endmodule
